bip_control_unit: RTL and testbench

//  Multi-cycle sequencer for the BIP processor: fetches 16-bit instructions, decodes them and drives the

---
 rtl/bip_pkg.sv | 32 +++
 rtl/bip_instr_decoder.sv | 66 ++++++
 rtl/bip_control_unit.sv | 124 ++++++++++++
 tb/tb_bip_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared constants for the BIP sequencer: opcode values, FSM state encoding and
// datapath select encodings used by the decoder and the control unit.
package bip_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt
    } state_e;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;
    localparam logic       SEL_B_MEM = 1'b0;
    localparam logic       SEL_B_IMM = 1'b1;
    localparam logic       ALU_ADD   = 1'b1;
    localparam logic       ALU_SUB   = 1'b0;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder: maps an opcode to the sequencing flags and the
// datapath control word (operand muxes and ALU operation).
module bip_instr_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_mem,
    output logic             is_store,
    output logic             wr_acc_en,
    output logic [1:0]       sel_a,
    output logic             sel_b,
    output logic             alu_op,
    output logic             is_halt,
    output logic             illegal
);

    always_comb begin
        is_mem    = 1'b0;
        is_store  = 1'b0;
        wr_acc_en = 1'b0;
        sel_a     = SEL_A_MEM;
        sel_b     = SEL_B_MEM;
        alu_op    = ALU_SUB;
        is_halt   = 1'b0;
        illegal   = 1'b0;
        unique case (opcode)
            OP_HLT:  is_halt = 1'b1;
            OP_STO: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_LD: begin
                is_mem    = 1'b1;
                wr_acc_en = 1'b1;
            end
            OP_LDI: begin
                wr_acc_en = 1'b1;
                sel_a     = SEL_A_IMM;
            end
            OP_ADD: begin
                is_mem    = 1'b1;
                wr_acc_en = 1'b1;
                sel_a     = SEL_A_ALU;
                alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                wr_acc_en = 1'b1;
                sel_a     = SEL_A_ALU;
                sel_b     = SEL_B_IMM;
                alu_op    = ALU_ADD;
            end
            OP_SUB: begin
                is_mem    = 1'b1;
                wr_acc_en = 1'b1;
                sel_a     = SEL_A_ALU;
            end
            OP_SUBI: begin
                wr_acc_en = 1'b1;
                sel_a     = SEL_A_ALU;
                sel_b     = SEL_B_IMM;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP multi-cycle sequencer: owns PC, IR and halt state; sequences fetch, decode,
// data-memory access and execute, and drives the accumulator datapath controls.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int unsigned PC_W   = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OPER_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [OPER_W-1:0] dmem_addr,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] operand_ext,
    output logic [1:0]        sel_a,
    output logic              sel_b,
    output logic              alu_op,
    output logic              wr_acc,
    output logic              retired,
    output logic              illegal_op,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic       is_mem, is_store, wr_acc_en, is_halt, illegal;
    logic       dec_sel_b, dec_alu_op;
    logic [1:0] dec_sel_a;
    logic       ctrl_active;

    bip_instr_decoder u_dec (
        .opcode    (ir_q[DATA_W-1 -: OPC_W]),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .wr_acc_en (wr_acc_en),
        .sel_a     (dec_sel_a),
        .sel_b     (dec_sel_b),
        .alu_op    (dec_alu_op),
        .is_halt   (is_halt),
        .illegal   (illegal)
    );

    assign imem_addr   = pc_q;
    assign dmem_addr   = ir_q[OPER_W-1:0];
    assign operand_ext = {{(DATA_W-OPER_W){ir_q[OPER_W-1]}}, ir_q[OPER_W-1:0]};

    // The control word is only presented while an instruction is in flight.
    assign sel_a  = ctrl_active ? dec_sel_a  : SEL_A_MEM;
    assign sel_b  = ctrl_active ? dec_sel_b  : SEL_B_MEM;
    assign alu_op = ctrl_active ? dec_alu_op : ALU_SUB;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req    = 1'b0;
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        wr_acc      = 1'b0;
        retired     = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;
        ctrl_active = 1'b0;
        unique case (state_q)
            StFetch: begin
                // Reset state is FETCH, but no request may be visible while held in reset.
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ctrl_active = 1'b1;
                if (is_halt) begin
                    state_d = StHalt;
                end else if (is_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StMem: begin
                ctrl_active = 1'b1;
                dmem_wr     = is_store;
                dmem_rd     = !is_store;
                if (dmem_ack) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                ctrl_active = 1'b1;
                wr_acc      = wr_acc_en;
                retired     = 1'b1;
                illegal_op  = illegal;
                pc_d        = pc_q + PC_W'(1);
                state_d     = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench for bip_control_unit: instruction-level timing model with
// per-cycle compare, memory responders with programmable wait states, directed programs.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack, dmem_rd, dmem_wr, dmem_ack;
    logic [10:0] imem_addr, dmem_addr;
    logic [15:0] imem_data, operand_ext;
    logic [1:0]  sel_a;
    logic        sel_b, alu_op, wr_acc, retired, illegal_op, halted;

    bip_control_unit #(.PC_W(11), .DATA_W(16), .OPER_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .operand_ext(operand_ext), .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op),
        .wr_acc(wr_acc), .retired(retired), .illegal_op(illegal_op), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       legal, halt, mem, store, wacc;
        logic [1:0] sa;
        logic       sb, aop;
    } row_t;

    int          checks = 0, failures = 0;
    logic [15:0] prog [0:2047];
    int          imem_wait = 0, dmem_wait = 0;

    logic [10:0] m_pc;
    logic [15:0] m_ir;
    bit          busy = 0, m_halted = 0;
    int          cyc = 0, t_fetch = 0;
    row_t        e;

    int          wacc_cyc[$];
    logic [10:0] fetch_log[$];
    logic [15:0] ext_log[$];
    logic [1:0]  sa_log[$];
    logic        sb_log[$], aop_log[$];
    int          rd_cycles, wr_cycles, illegal_cnt, retire_cnt, halt_cyc;
    logic [10:0] rd_addr, wr_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction table as written in the ISA description.
    function automatic row_t spec_row(input logic [4:0] opc);
        row_t r;
        r = '0;
        r.legal = 1'b1;
        case (opc)
            5'd0: r.halt = 1'b1;
            5'd1: begin r.mem = 1'b1; r.store = 1'b1; end
            5'd2: begin r.mem = 1'b1; r.wacc = 1'b1; r.sa = 2'd0; end
            5'd3: begin r.wacc = 1'b1; r.sa = 2'd1; end
            5'd4: begin r.mem = 1'b1; r.wacc = 1'b1; r.sa = 2'd2; r.aop = 1'b1; end
            5'd5: begin r.wacc = 1'b1; r.sa = 2'd2; r.sb = 1'b1; r.aop = 1'b1; end
            5'd6: begin r.mem = 1'b1; r.wacc = 1'b1; r.sa = 2'd2; end
            5'd7: begin r.wacc = 1'b1; r.sa = 2'd2; r.sb = 1'b1; end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        int s;
        s = int'(v);
        if (s >= 1024) s = s - 2048;
        return s[15:0];
    endfunction

    // Memory responders: ack after the configured number of wait cycles.
    initial begin
        int ic, dc;
        ic = 0; dc = 0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_data = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (ic >= imem_wait) begin
                    imem_ack = 1'b1; imem_data = prog[imem_addr]; ic = 0;
                end else begin
                    imem_ack = 1'b0; imem_data = 16'hDEAD; ic++;
                end
            end else begin
                imem_ack = 1'b0; ic = 0;
            end
            if (dmem_rd || dmem_wr) begin
                if (dc >= dmem_wait) begin
                    dmem_ack = 1'b1; dc = 0;
                end else begin
                    dmem_ack = 1'b0; dc++;
                end
            end else begin
                dmem_ack = 1'b0; dc = 0;
            end
        end
    end

    // Per-cycle compare against the instruction-level timing model.
    initial begin
        int   k, mem_len;
        logic mem_now, exec_now;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("reset_outputs", {imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, operand_ext,
                    sel_a, sel_b, alu_op, wr_acc, retired, illegal_op, halted}, 64'd0);
                m_pc = '0; busy = 0; m_halted = 0; cyc = 0;
            end else begin
                cyc++;
                chk("rd_wr_exclusive", dmem_rd & dmem_wr, 0);
                if (m_halted) begin
                    chk("halt_flag", halted, 1);
                    chk("halt_quiet", {imem_req, dmem_rd, dmem_wr, wr_acc, retired, illegal_op,
                        sel_a, sel_b, alu_op}, 0);
                end else if (!busy) begin
                    chk("fetch_req", imem_req, 1);
                    chk("fetch_addr", imem_addr, m_pc);
                    chk("fetch_quiet", {dmem_rd, dmem_wr, wr_acc, retired, illegal_op, halted,
                        sel_a, sel_b, alu_op}, 0);
                    if (imem_ack) begin
                        m_ir = prog[m_pc];
                        e = spec_row(m_ir[15:11]);
                        t_fetch = cyc;
                        busy = 1;
                        fetch_log.push_back(m_pc);
                    end
                end else begin
                    k = cyc - t_fetch;
                    mem_len = (e.mem && e.legal) ? 1 + dmem_wait : 0;
                    mem_now = (k >= 2) && (k < 2 + mem_len);
                    exec_now = !e.halt && (k == 2 + mem_len);
                    chk("busy_no_fetch", imem_req, 0);
                    chk("busy_not_halted", halted, 0);
                    chk("operand_ext", operand_ext, sext11(m_ir[10:0]));
                    chk("ctrl_word", {sel_a, sel_b, alu_op}, {e.sa, e.sb, e.aop});
                    chk("dmem_rd", dmem_rd, mem_now && !e.store);
                    chk("dmem_wr", dmem_wr, mem_now && e.store);
                    if (mem_now) chk("dmem_addr", dmem_addr, m_ir[10:0]);
                    chk("retired", retired, exec_now);
                    chk("wr_acc", wr_acc, exec_now && e.wacc);
                    chk("illegal_op", illegal_op, exec_now && !e.legal);
                    if (dmem_rd) begin rd_cycles++; rd_addr = dmem_addr; end
                    if (dmem_wr) begin wr_cycles++; wr_addr = dmem_addr; end
                    if (wr_acc) begin
                        wacc_cyc.push_back(cyc); ext_log.push_back(operand_ext);
                        sa_log.push_back(sel_a); sb_log.push_back(sel_b); aop_log.push_back(alu_op);
                    end
                    if (illegal_op) illegal_cnt++;
                    if (retired) retire_cnt++;
                    if (e.halt) begin
                        m_halted = 1; busy = 0; halt_cyc = cyc + 1;
                    end else if (exec_now) begin
                        busy = 0; m_pc = m_pc + 11'd1;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        wacc_cyc.delete(); fetch_log.delete(); ext_log.delete();
        sa_log.delete(); sb_log.delete(); aop_log.delete();
        rd_cycles = 0; wr_cycles = 0; illegal_cnt = 0; retire_cnt = 0; halt_cyc = 0;
        rd_addr = '0; wr_addr = '0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        clear_logs();
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n;
        n = 0;
        while (!m_halted && n < budget) begin
            @(negedge clk); #2; n++;
        end
        if (!m_halted) chk({name, "_halt_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
        #2;
    endtask

    initial begin
        int n;
        // 1: LDI 5; ADDI 3; STO 7; HLT
        clear_prog();
        prog[0] = 16'h1805; prog[1] = 16'h2803; prog[2] = 16'h0807; prog[3] = 16'h0000;
        do_reset();
        wait_halt(60, "t1");
        chk("t1_wacc_count", wacc_cyc.size(), 2);
        if (wacc_cyc.size() >= 2) begin
            chk("t1_wacc_cycle0", wacc_cyc[0], 3);
            chk("t1_wacc_cycle1", wacc_cyc[1], 6);
        end
        chk("t1_store_addr", wr_addr, 11'd7);
        chk("t1_store_cycles", wr_cycles, 1);
        chk("t1_fetches", fetch_log.size(), 4);
        chk("t1_halt_cycle", halt_cyc, 13);
        chk("t1_halted", halted, 1);

        // 2: sign extension of the operand field
        clear_prog();
        prog[0] = 16'h1FFF; prog[1] = 16'h1BFF; prog[2] = 16'h0000;
        do_reset();
        wait_halt(40, "t2");
        chk("t2_wacc_count", ext_log.size(), 2);
        if (ext_log.size() >= 2) begin
            chk("t2_ext_7ff", ext_log[0], 16'hFFFF);
            chk("t2_ext_3ff", ext_log[1], 16'h03FF);
            chk("t2_sel_a", sa_log[0], 2'b01);
        end

        // 3: SUB 2 with three data wait states
        clear_prog();
        prog[0] = 16'h3002; prog[1] = 16'h0000;
        dmem_wait = 3;
        do_reset();
        wait_halt(40, "t3");
        chk("t3_rd_cycles", rd_cycles, 4);
        chk("t3_rd_addr", rd_addr, 11'd2);
        chk("t3_wacc_count", wacc_cyc.size(), 1);
        if (wacc_cyc.size() >= 1) begin
            chk("t3_alu_op", aop_log[0], 0);
            chk("t3_sel_b", sb_log[0], 0);
            chk("t3_wacc_cycle", wacc_cyc[0], 7);
        end
        dmem_wait = 0;

        // 4: undefined opcode 11111
        clear_prog();
        prog[0] = 16'hF800; prog[1] = 16'h0000;
        do_reset();
        wait_halt(40, "t4");
        chk("t4_illegal_cnt", illegal_cnt, 1);
        chk("t4_retired_cnt", retire_cnt, 1);
        chk("t4_mem_cycles", rd_cycles + wr_cycles, 0);
        chk("t4_wacc_count", wacc_cyc.size(), 0);
        chk("t4_fetches", fetch_log.size(), 2);
        if (fetch_log.size() >= 2) chk("t4_next_pc", fetch_log[1], 11'd1);

        // 5: PC wrap after executing the instruction at 0x7FF
        for (int i = 0; i < 2048; i++) prog[i] = 16'h2801;
        do_reset();
        n = 0;
        while (fetch_log.size() < 2049 && n < 7000) begin
            @(negedge clk); #2; n++;
        end
        chk("t5_fetch_count_reached", fetch_log.size() >= 2049, 1);
        if (fetch_log.size() >= 2049) begin
            chk("t5_last_addr", fetch_log[2047], 11'h7FF);
            chk("t5_wrap_addr", fetch_log[2048], 11'h000);
        end

        // 6: reset asserted while a data read is outstanding
        clear_prog();
        prog[0] = 16'h1009; prog[1] = 16'h0000;
        dmem_wait = 5;
        do_reset();
        n = 0;
        while (!dmem_rd && n < 20) begin
            @(negedge clk); #2; n++;
        end
        chk("t6_in_mem", dmem_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, operand_ext,
            sel_a, sel_b, alu_op, wr_acc, retired, illegal_op, halted}, 64'd0);
        do_reset();
        n = 0;
        while (fetch_log.size() < 1 && n < 10) begin
            @(negedge clk); #2; n++;
        end
        chk("t6_refetch_seen", fetch_log.size() >= 1, 1);
        if (fetch_log.size() >= 1) chk("t6_refetch_addr", fetch_log[0], 11'd0);
        wait_halt(40, "t6");
        chk("t6_rd_cycles", rd_cycles, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
